alpha_fetch_unit: RTL and testbench
===================================

Name: alpha_fetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the alpha_processor decode/execute path.
- Holds the fetch PC and issues in-order word requests to instruction memory.
- Buffers returned instructions in a small queue and presents them, with their PCs, through a valid/ready handshake.
- Handles control-flow redirects by flushing the queue and discarding stale in-flight responses.

Parameters:
- XLEN, 32, address and instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, instruction queue entries and maximum outstanding requests (power of 2, ≥2).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- imem_req_valid  output  1  request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  XLEN  word-aligned fetch address.
- imem_rsp_valid  input  1  response valid; always in request order, latency ≥1 cycle.
- imem_rsp_data  input  XLEN  instruction word.
- redirect_valid  input  1  one-cycle pulse: branch/jump taken.
- redirect_pc  input  XLEN  new fetch target; bits [1:0] are ignored and forced to 0.
- if_valid  output  1  instruction available to decode.
- if_ready  input  1  decode accepts the instruction.
- if_instr  output  XLEN  instruction word.
- if_pc  output  XLEN  PC of if_instr.

Behaviour:
- Reset is sampled on clk when reset==0:
  - State goes to BOOT.
  - fetch_pc=RESET_PC, queue count=0, outstanding=0, drop_cnt=0.
  - Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0.
- Instruction memory shares this reset. Any response arriving while outstanding==0 is ignored.
- FSM states:
  - BOOT: no requests. Next cycle goes to RUN.
  - RUN: imem_req_valid=1 iff (count+outstanding)<DEPTH. imem_req_addr=fetch_pc.
    - On req fire (valid&&ready): fetch_pc+=4 (wraps modulo 2^XLEN), outstanding+=1.
  - DRAIN: imem_req_valid=0. Each response decrements drop_cnt and outstanding; its data is discarded.
    - Returns to RUN in the cycle after drop_cnt reaches 0.
- Responses in RUN:
  - Data is pushed into the queue tagged with its PC. The tag comes from a parallel PC FIFO captured at request time, or equivalent logic.
  - outstanding-=1.
  - Queue overflow cannot occur by construction. An assertion fires if a push happens when count==DEPTH.
- Output side:
  - if_valid=(count>0). if_instr/if_pc show the queue head.
  - Pop on if_valid&&if_ready. Head data holds stable while if_valid&&!if_ready.
  - Push and pop in the same cycle leave count unchanged. A response into an empty queue is visible on if_valid the next cycle; there is no bypass.
- Redirect (any state except BOOT, evaluated on the edge where redirect_valid==1):
  - Queue flushed (count=0). if_valid=0 the next cycle.
  - fetch_pc={redirect_pc[XLEN-1:2],2'b00}.
  - drop_cnt = outstanding after this cycle's fire and response updates.
    - If drop_cnt is 0: state=RUN.
    - Otherwise: state=DRAIN.
  - A request issued in the redirect cycle still counts as outstanding and is dropped.
  - A response arriving in the redirect cycle is discarded.
  - A pop in the redirect cycle is honoured (decode saw it); the rest of the queue is flushed.
  - Redirect during DRAIN: drop_cnt is recomputed the same way; the latest target wins.
- reset==0 mid-operation aborts everything on that edge, including a simultaneous redirect.
- Latency: on an idle queue with 1-cycle memory, the first instruction appears on if_valid 3 cycles after reset is released:
  - BOOT cycle.
  - Request cycle.
  - Response-to-queue cycle.
- Throughput: 1 instruction/cycle with ready memory and if_ready=1.

Test Plan:
1. Reset release, RESET_PC=0, 1-cycle memory returning addr>>2, if_ready=1 -> if_pc sequence 0,4,8,12 on consecutive cycles; if_instr 0,1,2,3; first if_valid on cycle 3.
2. if_ready=0 for 10 cycles -> exactly 4 requests issued (0..0xC); imem_req_valid=0 afterwards; queue holds 0..0xC. Then if_ready=1 -> fetch resumes at 0x10 with no loss or duplication.
3. 3-cycle memory, redirect_pc=0x103 pulsed with 2 outstanding -> state DRAIN; both stale responses discarded; next if_pc=0x100, then 0x104.
4. Redirect to 0x200 in the same cycle as a response and an if_valid&&if_ready pop -> popped instruction is consumed; the response is dropped; next if_pc=0x200.
5. Back-to-back redirects 0x300 then 0x400 during DRAIN -> no if_pc from 0x300 is ever emitted; the first emitted if_pc is 0x400.
6. reset=0 asserted for one cycle mid-stream with 3 outstanding -> all outputs return to reset values; the fetch restarts at RESET_PC; no stale instruction is emitted.

Source files
------------

// File: rtl/alpha_fetch_unit.sv
// Instruction-fetch front end: issues in-order word fetches, buffers returned
// instructions with their PCs, and flushes/drains on control-flow redirects.
module alpha_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];
  localparam logic [CW:0]   DEPTH_X = DEPTH[CW:0];

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [AW-1:0]   hd_q, hd_d, tl_q, tl_d;
  logic [AW-1:0]   pf_wr_q, pf_wr_d, pf_rd_q, pf_rd_d;

  logic [XLEN-1:0] q_instr [DEPTH];
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [XLEN-1:0] pf_pc   [DEPTH];

  logic          fire, rsp_acc, redir, push, pop;
  logic [CW:0]   inflight;
  logic          unused_ok;

  assign unused_ok = ^redirect_pc[1:0];
  assign inflight  = {1'b0, count_q} + {1'b0, outst_q};
  assign fire      = imem_req_valid & imem_req_ready;
  // Responses with nothing outstanding belong to a memory that was reset with us.
  assign rsp_acc   = imem_rsp_valid & (outst_q != '0);
  assign redir     = redirect_valid & (state_q != BOOT);
  assign push      = rsp_acc & (state_q == RUN) & ~redir;
  assign pop       = if_valid & if_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      hd_q       <= '0;
      tl_q       <= '0;
      pf_wr_q    <= '0;
      pf_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      hd_q       <= hd_d;
      tl_q       <= tl_d;
      pf_wr_q    <= pf_wr_d;
      pf_rd_q    <= pf_rd_d;
    end
  end

  // Storage needs no reset: count/outstanding gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[tl_q] <= imem_rsp_data;
      q_pc[tl_q]    <= pf_pc[pf_rd_q];
    end
    if (fire) pf_pc[pf_wr_q] <= fetch_pc_q;
  end

  always_ff @(posedge clk) begin
    if (reset && push) assert (count_q != DEPTH_C);
  end

  always_comb begin
    outst_d    = outst_q + CW'(fire) - CW'(rsp_acc);
    fetch_pc_d = fetch_pc_q;
    if (fire)  fetch_pc_d = fetch_pc_q + XLEN'(4);
    if (redir) fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    hd_d    = pop  ? hd_q + AW'(1) : hd_q;
    tl_d    = push ? tl_q + AW'(1) : tl_q;
    count_d = count_q + CW'(push) - CW'(pop);
    if (redir) begin
      count_d = '0;
      hd_d    = tl_q;
    end
    drop_d = drop_q;
    if (redir)                           drop_d = outst_d;
    else if (state_q == DRAIN && rsp_acc) drop_d = drop_q - CW'(1);
    // Stale responses still retire their PC slot so the tag FIFO stays aligned.
    pf_wr_d = pf_wr_q + AW'(fire);
    pf_rd_d = pf_rd_q + AW'(rsp_acc);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (redir) state_d = (outst_d == '0) ? RUN : DRAIN;
      DRAIN:   if (redir) state_d = (outst_d == '0) ? RUN : DRAIN;
               else       state_d = (drop_d == '0)  ? RUN : DRAIN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    imem_req_valid = (state_q == RUN) && (inflight < DEPTH_X);
    imem_req_addr  = fetch_pc_q;
    if_valid       = (count_q != '0);
    if_instr       = if_valid ? q_instr[hd_q] : '0;
    if_pc          = if_valid ? q_pc[hd_q]    : '0;
  end

endmodule

// File: tb/tb_alpha_fetch_unit.sv
// Directed bench for alpha_fetch_unit: a latency-configurable memory model and
// a scoreboard of the expected (pc, instr) stream, checked on every pop.
module tb_alpha_fetch_unit;

  logic        clk, reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;

  alpha_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  mreq_t       memq[$];
  exp_t        sb[$];
  int          cyc = 0, lat = 1, fire_cnt = 0, n_emit = 0;
  int          n_vec = 0, n_err = 0;
  logic [31:0] last_addr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic sb_load(input logic [31:0] pc);
    sb.delete();
    for (int i = 0; i < 64; i++) sb.push_back('{pc + 32'(4*i), (pc + 32'(4*i)) >> 2});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 0; redirect_valid = 0;
    @(posedge clk); #1;
    reset = 1;
    sb_load(32'h0);
  endtask

  task automatic wait_emit(input int n, input int bound, input string tag);
    int target;
    target = n_emit + n;
    for (int i = 0; i < bound && n_emit < target; i++) begin
      @(posedge clk); #1;
    end
    check(tag, 32'(n_emit >= target), 32'd1);
  endtask

  task automatic wait_outst(input int n, input int bound, input string tag);
    for (int i = 0; i < bound && memq.size() != n; i++) begin
      @(posedge clk); #1;
    end
    check(tag, 32'(memq.size()), 32'(n));
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_reqv"},  32'(imem_req_valid), 32'd0);
    check({tag, "_addr"},  imem_req_addr,       32'h0);
    check({tag, "_ifv"},   32'(if_valid),       32'd0);
    check({tag, "_instr"}, if_instr,            32'h0);
    check({tag, "_pc"},    if_pc,               32'h0);
  endtask

  // Memory: in-order, fixed latency 'lat', returns addr>>2; shares reset.
  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      memq.delete();
      fire_cnt = 0;
    end else begin
      if (imem_rsp_valid && memq.size() > 0) void'(memq.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        memq.push_back('{imem_req_addr, cyc + lat});
        fire_cnt++;
        last_addr = imem_req_addr;
      end
    end
  end

  always @(negedge clk) begin
    if (memq.size() > 0 && memq[0].due <= cyc + 1) begin
      imem_rsp_valid = 1;
      imem_rsp_data  = memq[0].addr >> 2;
    end else begin
      imem_rsp_valid = 0;
      imem_rsp_data  = '0;
    end
  end

  // Every instruction consumed by decode must be the next one expected.
  always @(negedge clk) begin
    if (reset && if_valid && if_ready) begin
      n_emit++;
      if (sb.size() == 0) check("sb_under", 32'(sb.size()), 32'd1);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("emit_pc",    if_pc,    e.pc);
        check("emit_instr", if_instr, e.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0; imem_req_ready = 1; redirect_valid = 0; redirect_pc = '0; if_ready = 1;
    repeat (3) @(posedge clk);

    // 1: reset values, 3-cycle first-instruction latency, full throughput
    lat = 1; if_ready = 1;
    do_reset();
    check_reset_outs("t1_rst");
    @(posedge clk); #1;
    check("t1_e1_ifv", 32'(if_valid), 32'd0);
    check("t1_e1_reqv", 32'(imem_req_valid), 32'd1);
    @(posedge clk); #1;
    check("t1_e2_ifv", 32'(if_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("t1_ifv", 32'(if_valid), 32'd1);
      check("t1_pc", if_pc, 32'(4*i));
      check("t1_instr", if_instr, 32'(i));
    end

    // 2: decode stalled -> exactly DEPTH requests, then lossless resume
    lat = 1; if_ready = 0;
    do_reset();
    repeat (10) begin @(posedge clk); #1; end
    check("t2_fires", 32'(fire_cnt), 32'd4);
    check("t2_last_addr", last_addr, 32'hC);
    check("t2_reqv", 32'(imem_req_valid), 32'd0);
    check("t2_ifv", 32'(if_valid), 32'd1);
    check("t2_head_pc", if_pc, 32'h0);
    if_ready = 1;
    wait_emit(8, 40, "t2_emit");

    // 3: 3-cycle memory, redirect with 2 outstanding -> drain, resume at 0x100
    lat = 3; if_ready = 1;
    do_reset();
    wait_outst(2, 20, "t3_outst");
    redirect_valid = 1; redirect_pc = 32'h103;
    @(posedge clk); #1;
    redirect_valid = 0;
    sb_load(32'h100);
    check("t3_drain_reqv", 32'(imem_req_valid), 32'd0);
    check("t3_flush_ifv", 32'(if_valid), 32'd0);
    wait_emit(4, 60, "t3_emit");

    // 4: redirect coinciding with a response and a pop
    lat = 1; if_ready = 1;
    do_reset();
    wait_emit(3, 20, "t4_warm");
    redirect_valid = 1; redirect_pc = 32'h200;
    @(negedge clk); #1;
    check("t4_rsp_same_cyc", 32'(imem_rsp_valid), 32'd1);
    check("t4_pop_same_cyc", 32'(if_valid && if_ready), 32'd1);
    @(posedge clk); #1;
    redirect_valid = 0;
    sb_load(32'h200);
    check("t4_flush_ifv", 32'(if_valid), 32'd0);
    wait_emit(4, 40, "t4_emit");

    // 5: back-to-back redirects while draining -> latest target wins
    lat = 3; if_ready = 1;
    do_reset();
    wait_emit(2, 30, "t5_warm");
    redirect_valid = 1; redirect_pc = 32'h300;
    @(posedge clk); #1;
    check("t5_drain1_reqv", 32'(imem_req_valid), 32'd0);
    redirect_pc = 32'h400;
    @(posedge clk); #1;
    redirect_valid = 0;
    sb_load(32'h400);
    check("t5_drain2_reqv", 32'(imem_req_valid), 32'd0);
    check("t5_flush_ifv", 32'(if_valid), 32'd0);
    wait_emit(4, 60, "t5_emit");

    // 6: one-cycle reset mid-stream with 3 outstanding
    lat = 3; if_ready = 1;
    do_reset();
    wait_outst(3, 20, "t6_outst");
    reset = 0;
    @(posedge clk); #1;
    reset = 1;
    sb_load(32'h0);
    check_reset_outs("t6_rst");
    wait_emit(4, 60, "t6_emit");

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
